// File: rtl/mpu_imul_seq_pkg.sv
// Shared types and defaults for the MPU scalar-multiply sequencer.
// Holds the FSM encoding and the flattened-matrix element offset helper.
package mpu_imul_seq_pkg;

   localparam int unsigned N_DEF     = 5;
   localparam int unsigned W_DEF     = 8;
   localparam int unsigned LANES_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Bit offset of element (i, j) in a flattened NxN matrix of W-bit elements.
   function automatic int unsigned elem_off(input int unsigned i, input int unsigned j,
                                            input int unsigned n, input int unsigned w);
      return w * (i + n * j);
   endfunction

endpackage

// File: rtl/mpu_imul_lane.sv
// One multiplier lane: W x W unsigned multiply, keeping only the low W bits.
module mpu_imul_lane #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] p_o
);

   // The W-bit context truncates the product, giving wrap-around mod 2^W.
   assign p_o = a_i * b_i;

endmodule

// File: rtl/mpu_imul_seq.sv
// IMUL sequencer: latches an NxN matrix and a scalar, then sweeps the matrix
// LANES elements per cycle through the multiplier lanes to build the product.
module mpu_imul_seq
   import mpu_imul_seq_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned W     = W_DEF,
   parameter int unsigned LANES = LANES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [N*N*W-1:0] matrix_a,
   input  logic [W-1:0]     factor,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             result_valid,
   output logic [N*N*W-1:0] result
);

   localparam int unsigned NE   = N * N;
   localparam int unsigned IDXW = $clog2(NE) + 1;
   localparam logic [IDXW-1:0] IDX_STEP = IDXW'(LANES);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NE - LANES);

   state_e            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [NE*W-1:0]   a_q, a_d;
   logic [W-1:0]      factor_q, factor_d;
   logic [NE*W-1:0]   result_q, result_d;
   logic              result_valid_q, result_valid_d;

   logic [IDXW-1:0]   base_idx;
   int unsigned       lane_off [LANES];
   logic [W-1:0]      lane_a   [LANES];
   logic [W-1:0]      lane_p   [LANES];

   // idx reaches NE after the final sweep; clamp so lane reads stay in range.
   assign base_idx = (idx_q <= IDX_LAST) ? idx_q : '0;

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_off[l] = elem_off((int'(base_idx) + l) % N, (int'(base_idx) + l) / N, N, W);
         lane_a[l]   = a_q[lane_off[l] +: W];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      mpu_imul_lane #(.W(W)) u_lane (
         .a_i (lane_a[g]),
         .b_i (factor_q),
         .p_o (lane_p[g])
      );
   end

   // NOTE: every variable gets its hold value first, so no path leaves one unassigned (no latches).
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      a_d            = a_q;
      factor_d       = factor_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (start_valid) begin
               a_d            = matrix_a;
               factor_d       = factor;
               idx_d          = '0;
               result_valid_d = 1'b0;
               state_d        = ST_RUN;
            end
         end
         ST_RUN: begin
            // The current chunk is written even in an aborted cycle.
            for (int l = 0; l < LANES; l++) begin
               result_d[lane_off[l] +: W] = lane_p[l];
            end
            idx_d = idx_q + IDX_STEP;
            if (abort) begin
               state_d = ST_IDLE;
            end else if (idx_q == IDX_LAST) begin
               state_d        = ST_DONE;
               result_valid_d = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         idx_q          <= '0;
         a_q            <= '0;
         factor_q       <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         a_q            <= a_d;
         factor_q       <= factor_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign start_ready  = rst_n && (state_q == ST_IDLE);
   assign busy         = (state_q == ST_RUN);
   assign done         = (state_q == ST_DONE);
   assign result_valid = result_valid_q;
   assign result       = result_q;

endmodule
